// File: rtl/seq_det_pkg.sv
// Shared types and constants for the button-sequence detector.
package seq_det_pkg;

    localparam int unsigned KONAMI_LEN = 11;
    localparam int unsigned BTN_IDX_W  = 3;

    typedef enum logic [BTN_IDX_W-1:0] {
        UP    = 3'd0,
        DOWN  = 3'd1,
        LEFT  = 3'd2,
        RIGHT = 3'd3,
        B     = 3'd4,
        A     = 3'd5,
        START = 3'd6
    } btn_e;

    // Classification of the taps seen in one cycle.
    typedef enum logic [1:0] {
        TAP_NONE  = 2'd0,
        TAP_MATCH = 2'd1,
        TAP_MISS  = 2'd2
    } tap_ev_e;

    // Default code vector: element k at [k*BTN_IDX_W +: BTN_IDX_W].
    function automatic logic [KONAMI_LEN*BTN_IDX_W-1:0] konami_code();
        logic [KONAMI_LEN*BTN_IDX_W-1:0] v;
        btn_e                            seq [KONAMI_LEN];
        seq = '{UP, UP, DOWN, DOWN, LEFT, RIGHT, LEFT, RIGHT, B, A, START};
        v   = '0;
        for (int k = 0; k < int'(KONAMI_LEN); k++) begin
            v[k*BTN_IDX_W +: BTN_IDX_W] = seq[k];
        end
        return v;
    endfunction

endpackage

// File: rtl/btn_tap_tracker.sv
// Per-button held flag; a tap is the release of a button that was held.
module btn_tap_tracker (
    input  logic clk_i,
    input  logic reset_i,
    input  logic press_i,
    input  logic release_i,
    input  logic clear_i,
    output logic tap_c
);

    logic held_d;
    logic held_q;

    // Held flag update: clear first, then release wins over press.
    always_comb begin
        held_d = held_q;
        if (clear_i) begin
            held_d = 1'b0;
        end else if (release_i) begin
            held_d = 1'b0;
        end else if (press_i) begin
            held_d = 1'b1;
        end
    end

    // Held flag register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            held_q <= 1'b0;
        end else begin
            held_q <= held_d;
        end
    end

    assign tap_c = held_q & release_i;

endmodule

// File: rtl/seq_code_detector.sv
// Parametrised button-sequence detector driven by press/release strobes.
// Optional inter-tap timeout enabled by defining SEQ_DET_TIMEOUT_EN.
module seq_code_detector
    import seq_det_pkg::*;
#(
    parameter  int unsigned NUM_BTN        = 7,
    parameter  int unsigned SEQ_LEN        = 11,
    parameter  int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned IDX_W          = $clog2(NUM_BTN),
    localparam int unsigned PROG_W         = $clog2(SEQ_LEN + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NUM_BTN-1:0]       press_i,
    input  logic [NUM_BTN-1:0]       release_i,
    input  logic [SEQ_LEN*IDX_W-1:0] code_i,
    input  logic                     clear_i,
    output logic                     unlocked_o,
    output logic [PROG_W-1:0]        progress_o,
    output logic                     error_o
);

    // Elaboration-time parameter sanity checks.
    if (NUM_BTN < 2) begin : g_chk_num_btn
        $error("seq_code_detector: NUM_BTN must be >= 2");
    end
    if (SEQ_LEN < 1) begin : g_chk_seq_len
        $error("seq_code_detector: SEQ_LEN must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
        $error("seq_code_detector: TIMEOUT_CYCLES must be >= 1");
    end

    logic [NUM_BTN-1:0] tap_c;
    logic               tap_any_c;
    logic               tap_multi_c;
    logic [IDX_W-1:0]   tap_idx_c;
    logic [IDX_W-1:0]   cur_code_c;
    logic [IDX_W-1:0]   first_code_c;
    tap_ev_e            tap_ev_c;
    logic               timeout_c;

    logic [PROG_W-1:0]  progress_d;
    logic [PROG_W-1:0]  progress_q;
    logic               unlocked_d;
    logic               unlocked_q;
    logic               error_d;
    logic               error_q;

    // One held-flag tracker per button.
    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        btn_tap_tracker u_tracker (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .press_i   (press_i[b]),
            .release_i (release_i[b]),
            .clear_i   (clear_i),
            .tap_c     (tap_c[b])
        );
    end

    assign tap_any_c    = |tap_c;
    assign tap_multi_c  = |(tap_c & (tap_c - NUM_BTN'(1)));
    assign first_code_c = code_i[IDX_W-1:0];

    // Encode the (single) tapped button to its index.
    always_comb begin
        tap_idx_c = '0;
        for (int unsigned b = 0; b < NUM_BTN; b++) begin
            if (tap_c[b]) begin
                tap_idx_c = IDX_W'(b);
            end
        end
    end

    // Select the code element expected at the current progress.
    always_comb begin
        cur_code_c = '0;
        for (int unsigned k = 0; k < SEQ_LEN; k++) begin
            if (progress_q == PROG_W'(k)) begin
                cur_code_c = code_i[k*IDX_W +: IDX_W];
            end
        end
    end

    // Classify this cycle's taps; simultaneous taps always count as a miss.
    always_comb begin
        tap_ev_c = TAP_NONE;
        if (tap_any_c) begin
            if (!tap_multi_c && (tap_idx_c == cur_code_c)) begin
                tap_ev_c = TAP_MATCH;
            end else begin
                tap_ev_c = TAP_MISS;
            end
        end
    end

    // Progress and pulse next-state.
    always_comb begin
        progress_d = progress_q;
        unlocked_d = 1'b0;
        error_d    = 1'b0;
        if (clear_i) begin
            progress_d = '0;
        end else begin
            case (tap_ev_c)
                TAP_MATCH: begin
                    if (progress_q == PROG_W'(SEQ_LEN - 1)) begin
                        progress_d = '0;
                        unlocked_d = 1'b1;
                    end else begin
                        progress_d = progress_q + PROG_W'(1);
                    end
                end
                TAP_MISS: begin
                    error_d = (progress_q != '0);
                    if (!tap_multi_c && (tap_idx_c == first_code_c)) begin
                        progress_d = PROG_W'(1);
                    end else begin
                        progress_d = '0;
                    end
                end
                default: begin
                    if (timeout_c) begin
                        progress_d = '0;
                        error_d    = 1'b1;
                    end
                end
            endcase
        end
    end

    // Progress and pulse registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            progress_q <= '0;
            unlocked_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            progress_q <= progress_d;
            unlocked_q <= unlocked_d;
            error_q    <= error_d;
        end
    end

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] idle_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q;

    // Idle-cycle counter: runs only while a partial sequence is pending.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        timeout_c  = 1'b0;
        if (clear_i || tap_any_c || (progress_q == '0)) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            idle_cnt_d = '0;
            timeout_c  = 1'b1;
        end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
    end

    // Idle counter register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    assign unlocked_o = unlocked_q;
    assign progress_o = progress_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_seq_code_detector.sv
// Bench for seq_code_detector with default parameters and the Konami code.
module tb_seq_code_detector;

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int TO         = 8;
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam int TO         = 1024;
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int NB = 7;
    localparam int SL = 11;

    logic        clk_i;
    logic        reset_i;
    logic [6:0]  press_i;
    logic [6:0]  release_i;
    logic [32:0] code_i;
    logic        clear_i;
    logic        unlocked_o;
    logic [3:0]  progress_o;
    logic        error_o;

    int checks = 0;
    int errors = 0;

    // Konami code as button indices: U U D D L R L R B A START.
    int code_arr [SL] = '{0, 0, 1, 1, 2, 3, 2, 3, 4, 5, 6};

    typedef struct packed {
        int       prog;
        int       idle;
        bit       unl;
        bit       err;
        bit [6:0] held;
    } mstate_t;

    mstate_t m;

    seq_code_detector #(
        .NUM_BTN        (NB),
        .SEQ_LEN        (SL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .press_i    (press_i),
        .release_i  (release_i),
        .code_i     (code_i),
        .clear_i    (clear_i),
        .unlocked_o (unlocked_o),
        .progress_o (progress_o),
        .error_o    (error_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: next observable state from this cycle's strobes.
    function automatic mstate_t model_next(mstate_t s, bit [6:0] pr, bit [6:0] rl, bit clr);
        mstate_t  n    = s;
        int       ntap = 0;
        int       b    = 0;
        bit [6:0] taps = s.held & rl;
        n.unl = 1'b0;
        n.err = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (rl[i]) n.held[i] = 1'b0;
            else if (pr[i]) n.held[i] = 1'b1;
            if (taps[i]) begin
                ntap++;
                b = i;
            end
        end
        if (clr) begin
            n.held = '0;
            n.prog = 0;
            n.idle = 0;
        end else if (ntap == 0) begin
            n.idle = 0;
            if (TIMEOUT_EN && s.prog != 0) begin
                n.idle = s.idle + 1;
                if (n.idle == TO) begin
                    n.prog = 0;
                    n.err  = 1'b1;
                    n.idle = 0;
                end
            end
        end else begin
            n.idle = 0;
            if (ntap > 1) begin
                n.err  = (s.prog != 0);
                n.prog = 0;
            end else if (b == code_arr[s.prog]) begin
                n.prog = s.prog + 1;
                if (n.prog == SL) begin
                    n.prog = 0;
                    n.unl  = 1'b1;
                end
            end else begin
                n.err  = (s.prog != 0);
                n.prog = (b == code_arr[0]) ? 1 : 0;
            end
        end
        return n;
    endfunction

    // Model state register.
    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) m <= '0;
        else         m <= model_next(m, press_i, release_i, clear_i);
    end

    // Every-cycle comparison against the model.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            check("model_progress", 32'(progress_o), 32'(m.prog));
            check("model_unlocked", 32'(unlocked_o), 32'(m.unl));
            check("model_error",    32'(error_o),    32'(m.err));
        end
    end

    task automatic drive(input logic [6:0] pr, input logic [6:0] rl, input logic clr);
        @(negedge clk_i);
        press_i   = pr;
        release_i = rl;
        clear_i   = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, 1'b0);
    endtask

    // Press, release, then one idle cycle in which the release result is visible.
    task automatic tap(input int b);
        logic [6:0] msk;
        msk = 7'(1) << b;
        drive(msk, '0, 1'b0);
        drive('0, msk, 1'b0);
        drive('0, '0, 1'b0);
    endtask

    initial begin
        logic [6:0] msk;
        reset_i   = 1'b1;
        press_i   = '0;
        release_i = '0;
        clear_i   = 1'b0;
        code_i    = seq_det_pkg::konami_code();
        repeat (2) @(negedge clk_i);
        check("reset_progress", 32'(progress_o), 32'd0);
        check("reset_unlocked", 32'(unlocked_o), 32'd0);
        check("reset_error",    32'(error_o),    32'd0);
        reset_i = 1'b0;
        idle(2);

        // Full Konami sequence.
        for (int k = 0; k < SL; k++) begin
            tap(code_arr[k]);
            if (k < SL - 1) check("konami_progress", 32'(progress_o), 32'(k + 1));
        end
        check("konami_unlocked", 32'(unlocked_o), 32'd1);
        check("konami_progress_end", 32'(progress_o), 32'd0);
        idle(1);
        check("konami_unlock_pulse_len", 32'(unlocked_o), 32'd0);

        // Second run: a tap during the unlocked cycle starts from zero.
        for (int k = 0; k < SL - 1; k++) tap(code_arr[k]);
        msk = 7'b1000001;
        drive(msk, '0, 1'b0);
        drive('0, 7'b1000000, 1'b0);
        drive('0, 7'b0000001, 1'b0);
        check("rerun_unlocked", 32'(unlocked_o), 32'd1);
        idle(1);
        check("tap_in_unlock_cycle", 32'(progress_o), 32'd1);
        drive('0, '0, 1'b1);
        idle(1);

        // Mismatch with error, then restart on code[0].
        tap(0); tap(0); tap(1);
        check("partial_progress", 32'(progress_o), 32'd3);
        tap(2);
        check("mismatch_error", 32'(error_o), 32'd1);
        check("mismatch_progress", 32'(progress_o), 32'd0);
        tap(0);
        check("restart_progress", 32'(progress_o), 32'd1);
        tap(0); tap(0);
        check("up3_progress", 32'(progress_o), 32'd1);
        check("up3_error", 32'(error_o), 32'd1);
        drive('0, '0, 1'b1);
        idle(1);

        // Release without prior press is not a tap.
        drive('0, 7'b0000001, 1'b0);
        idle(1);
        check("orphan_release_progress", 32'(progress_o), 32'd0);
        check("orphan_release_error", 32'(error_o), 32'd0);

        // Two simultaneous taps, then press+release in the same cycle.
        tap(0); tap(0);
        drive(7'b0000011, '0, 1'b0);
        drive('0, 7'b0000011, 1'b0);
        idle(1);
        check("double_tap_progress", 32'(progress_o), 32'd0);
        check("double_tap_error", 32'(error_o), 32'd1);
        tap(0);
        drive(7'b0000010, 7'b0000010, 1'b0);
        drive('0, 7'b0000010, 1'b0);
        idle(1);
        check("same_cycle_pr_progress", 32'(progress_o), 32'd1);
        drive('0, '0, 1'b1);
        idle(1);

        // Asynchronous reset mid-sequence.
        for (int k = 0; k < 6; k++) tap(code_arr[k]);
        check("pre_reset_progress", 32'(progress_o), 32'd6);
        #2 reset_i = 1'b1;
        #1;
        check("async_reset_progress", 32'(progress_o), 32'd0);
        check("async_reset_unlocked", 32'(unlocked_o), 32'd0);
        check("async_reset_error", 32'(error_o), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Synchronous clear at progress 4 ignores the tap in the same cycle.
        for (int k = 0; k < 4; k++) tap(code_arr[k]);
        check("pre_clear_progress", 32'(progress_o), 32'd4);
        drive(7'b0000100, '0, 1'b0);
        drive('0, 7'b0000100, 1'b1);
        idle(1);
        check("clear_progress", 32'(progress_o), 32'd0);
        check("clear_error", 32'(error_o), 32'd0);
        drive('0, 7'b0000001, 1'b0);
        idle(1);
        check("clear_drops_held", 32'(progress_o), 32'd0);

`ifdef SEQ_DET_TIMEOUT_EN
        // Timeout after TO idle cycles; a tap on the last allowed cycle survives.
        tap(0);
        idle(TO - 1);
        check("timeout_not_yet", 32'(progress_o), 32'd1);
        idle(1);
        check("timeout_progress", 32'(progress_o), 32'd0);
        check("timeout_error", 32'(error_o), 32'd1);
        tap(0);
        idle(TO - 3);
        tap(0);
        check("timeout_tap_in_time", 32'(progress_o), 32'd2);
`else
        // Without the timeout, partial progress is held indefinitely.
        tap(0);
        idle(1000);
        check("no_timeout_hold", 32'(progress_o), 32'd1);
        check("no_timeout_error", 32'(error_o), 32'd0);
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
